// File: rtl/serial_subtractor_8b.sv
// Bit-serial two's-complement subtractor: diff = a - b - bin, one bit per
// clock LSB first, through one full-subtractor cell and a borrow flop.
module serial_subtractor_8b #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             zero,
  output logic             neg,
  output logic             ovf,
  output logic [1:0]       dbg_state
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             brw_q, brw_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             amsb_q, amsb_d;
  logic             bmsb_q, bmsb_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bout_q, bout_d;
  logic             zero_q, zero_d;
  logic             neg_q, neg_d;
  logic             ovf_q, ovf_d;

  // Full-subtractor cell on the current LSBs of the operand shift registers.
  logic             a_bit, b_bit, d_bit, brw_nxt;
  logic [WIDTH-1:0] res_shift;

  always_comb begin
    a_bit     = a_sr_q[0];
    b_bit     = b_sr_q[0];
    d_bit     = a_bit ^ b_bit ^ brw_q;
    brw_nxt   = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & brw_q);
    res_shift = {d_bit, res_q[WIDTH-1:1]};
  end

  // Handshake: start is taken only on an edge where ready=1 (IDLE); inputs
  // are captured at that edge. done is a one-cycle pulse marking the cycle
  // in which diff and the flags first show the new result; they then hold
  // until the next done.
  always_comb begin
    state_d = state_q;
    a_sr_d  = a_sr_q;
    b_sr_d  = b_sr_q;
    res_d   = res_q;
    brw_d   = brw_q;
    cnt_d   = cnt_q;
    amsb_d  = amsb_q;
    bmsb_d  = bmsb_q;
    diff_d  = diff_q;
    bout_d  = bout_q;
    zero_d  = zero_q;
    neg_d   = neg_q;
    ovf_d   = ovf_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_sr_d  = a;
          b_sr_d  = b;
          brw_d   = bin;
          cnt_d   = '0;
          res_d   = '0;
          amsb_d  = a[WIDTH-1];
          bmsb_d  = b[WIDTH-1];
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        a_sr_d = a_sr_q >> 1;
        b_sr_d = b_sr_q >> 1;
        brw_d  = brw_nxt;
        res_d  = res_shift;
        if (cnt_q == LAST) begin
          // Last bit: all result outputs update together from the final cell.
          diff_d  = res_shift;
          bout_d  = brw_nxt;
          zero_d  = (res_shift == '0);
          neg_d   = d_bit;
          ovf_d   = (amsb_q ^ bmsb_q) & (amsb_q ^ d_bit);
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_sr_q  <= '0;
      b_sr_q  <= '0;
      res_q   <= '0;
      brw_q   <= 1'b0;
      cnt_q   <= '0;
      amsb_q  <= 1'b0;
      bmsb_q  <= 1'b0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
      zero_q  <= 1'b0;
      neg_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sr_q  <= a_sr_d;
      b_sr_q  <= b_sr_d;
      res_q   <= res_d;
      brw_q   <= brw_d;
      cnt_q   <= cnt_d;
      amsb_q  <= amsb_d;
      bmsb_q  <= bmsb_d;
      diff_q  <= diff_d;
      bout_q  <= bout_d;
      zero_q  <= zero_d;
      neg_q   <= neg_d;
      ovf_q   <= ovf_d;
    end
  end

  assign ready     = (state_q == S_IDLE);
  assign busy      = (state_q == S_RUN);
  assign done      = (state_q == S_DONE);
  assign diff      = diff_q;
  assign bout      = bout_q;
  assign zero      = zero_q;
  assign neg       = neg_q;
  assign ovf       = ovf_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_serial_subtractor_8b.sv
// Self-checking bench for serial_subtractor_8b: arithmetic reference model
// with a per-cycle compare process, plus directed vectors with literal results.
module tb_serial_subtractor_8b;

  localparam int W = 8;

  logic         clk   = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a     = '0;
  logic [W-1:0] b     = '0;
  logic         bin   = 1'b0;
  logic         ready, busy, done, bout, zero, neg, ovf;
  logic [W-1:0] diff;
  logic [1:0]   dbg_state;

  int n_vec    = 0;
  int n_err    = 0;
  int edge_cnt = 0;

  // Expected result packed as {ovf, neg, zero, bout, diff}.
  logic [W+3:0] exp_q[$];
  int           e0_q[$];
  logic [W+3:0] hold = '0;

  serial_subtractor_8b #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .bin(bin),
    .ready(ready), .busy(busy), .done(done), .diff(diff), .bout(bout),
    .zero(zero), .neg(neg), .ovf(ovf), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  function automatic logic [W+3:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                         input logic bi);
    logic [W:0] t;
    t = {1'b0, x} - {1'b0, y} - {{W{1'b0}}, bi};
    return {((x[W-1] ^ y[W-1]) & (x[W-1] ^ t[W-1])), t[W-1], (t[W-1:0] == '0), t[W],
            t[W-1:0]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s: bound expired (t=%0t)", name, $time);
  endtask

  // Model bookkeeping at each rising edge: idle when nothing is outstanding;
  // an op occupies its accept edge E0 through E0+W+1 (done cycle included).
  always @(posedge clk) begin
    edge_cnt++;
    if (!rst_n) begin
      exp_q.delete();
      e0_q.delete();
    end else if (exp_q.size() == 0) begin
      if (start) begin
        exp_q.push_back(model(a, b, bin));
        e0_q.push_back(edge_cnt);
      end
    end else if (edge_cnt - e0_q[0] == W + 1) begin
      void'(exp_q.pop_front());
      void'(e0_q.pop_front());
    end
  end

  // Per-cycle compare on the falling edge.
  always @(negedge clk) begin
    logic [W+3:0] outs;
    outs = {ovf, neg, zero, bout, diff};
    if (!rst_n) begin
      hold = '0;
      chk("rst_ctl", {29'd0, ready, busy, done}, 32'b100);
      chk("rst_out", {20'd0, outs}, 32'd0);
    end else if (exp_q.size() == 0) begin
      chk("idle_ctl", {29'd0, ready, busy, done}, 32'b100);
      chk("idle_hold", {20'd0, outs}, {20'd0, hold});
    end else if (edge_cnt - e0_q[0] < W) begin
      chk("run_ctl", {29'd0, ready, busy, done}, 32'b010);
      chk("run_hold", {20'd0, outs}, {20'd0, hold});
    end else begin
      chk("done_ctl", {29'd0, ready, busy, done}, 32'b001);
      chk("result", {20'd0, outs}, {20'd0, exp_q[0]});
      hold = exp_q[0];
    end
  end

  task automatic wait_ready();
    int i;
    @(negedge clk);
    for (i = 0; i < 50; i++) begin
      if (ready) break;
      @(negedge clk);
    end
    if (!ready) timeout("ready_wait");
    #1;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done) return;
      lat++;
    end
    timeout("done_wait");
  endtask

  task automatic scramble();
    a   = W'($urandom_range(0, 255));
    b   = W'($urandom_range(0, 255));
    bin = 1'($urandom_range(0, 1));
  endtask

  task automatic do_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic bi,
                       input logic [W+3:0] lit, input string nm);
    int lat;
    wait_ready();
    a = x; b = y; bin = bi; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    scramble();
    wait_done(lat);
    chk({nm, "_lat"}, lat, W);
    chk({nm, "_lit"}, {20'd0, ovf, neg, zero, bout, diff}, {20'd0, lit});
  endtask

  initial begin
    int lat;
    #1;
    chk("reset_ctl", {29'd0, ready, busy, done}, 32'b100);
    chk("reset_out", {20'd0, ovf, neg, zero, bout, diff}, 32'd0);
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;

    do_op(8'h5A, 8'h3C, 1'b0, 12'h01E, "5a_3c");
    do_op(8'h00, 8'h01, 1'b0, 12'h5FF, "00_01");
    do_op(8'h80, 8'h01, 1'b0, 12'h87F, "80_01");
    do_op(8'h10, 8'h10, 1'b0, 12'h200, "10_10");
    do_op(8'h05, 8'h02, 1'b1, 12'h002, "05_02_b");
    do_op(8'h00, 8'h00, 1'b1, 12'h5FF, "00_00_b");
    do_op(8'h7F, 8'hFF, 1'b0, 12'hD80, "7f_ff");
    do_op(8'h01, 8'hFF, 1'b0, 12'h102, "01_ff");
    do_op(8'hFF, 8'hFF, 1'b1, 12'h5FF, "ff_ff_b");

    // Start pulse during RUN must be ignored.
    wait_ready();
    a = 8'h5A; b = 8'h3C; bin = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (2) @(posedge clk);
    #1 a = 8'hFF; b = 8'h00; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(lat);
    chk("ign_lat", lat, W - 3);
    chk("ign_lit", {20'd0, ovf, neg, zero, bout, diff}, 32'h01E);
    repeat (4) @(negedge clk);

    // Reset in the middle of an operation.
    wait_ready();
    a = 8'h80; b = 8'h01; bin = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("abort_ctl", {29'd0, ready, busy, done}, 32'b100);
    chk("abort_out", {20'd0, ovf, neg, zero, bout, diff}, 32'd0);
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    do_op(8'h5A, 8'h3C, 1'b0, 12'h01E, "post_rst");

    repeat (4) @(negedge clk);
    chk("no_pending", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
